// File: rtl/ibex_irq_pkg.sv
// ibex_irq_pkg
// Shared types and constants for the ibex interrupt front-end.
//   irq_state_e : controller-facing interrupt FSM states
//   IRQ_ID_*    : exception cause ids of the interrupt sources
//   make_cause  : builds the 6-bit interrupt cause {1'b1, id}
package ibex_irq_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REQ         = 2'd1,
    HANDLER     = 2'd2,
    NMI_HANDLER = 2'd3
  } irq_state_e;

  localparam int unsigned IRQ_ID_SW        = 3;
  localparam int unsigned IRQ_ID_TIMER     = 7;
  localparam int unsigned IRQ_ID_EXT       = 11;
  localparam int unsigned IRQ_ID_FAST_BASE = 16;
  localparam int unsigned IRQ_ID_NMI       = 31;

  function automatic logic [5:0] make_cause(input logic [4:0] id);
    return {1'b1, id};
  endfunction

endpackage

// File: rtl/ibex_irq_ctrl_gen_prio_enc.sv
// ibex_irq_prio_enc
// Combinational priority encoder over the 32-entry eligible vector.
//   elig_i  : eligible sources indexed by cause id
//   valid_o : at least one source is eligible
//   id_o    : winning cause id
// Order, highest first: NMI (31), fast lines 30..16, external (11),
// software (3), timer (7).
module ibex_irq_prio_enc
  import ibex_irq_pkg::*;
(
  input  logic [31:0] elig_i,
  output logic        valid_o,
  output logic [4:0]  id_o
);

  // Later assignments override earlier ones, so checks run lowest priority first.
  always_comb begin
    id_o = '0;
    if (elig_i[IRQ_ID_TIMER]) id_o = 5'(IRQ_ID_TIMER);
    if (elig_i[IRQ_ID_SW])    id_o = 5'(IRQ_ID_SW);
    if (elig_i[IRQ_ID_EXT])   id_o = 5'(IRQ_ID_EXT);
    for (int i = IRQ_ID_FAST_BASE; i < 32; i++) begin
      if (elig_i[i]) id_o = 5'(i);
    end
  end

  assign valid_o = |elig_i;

endmodule

// File: rtl/ibex_irq_ctrl_gen.sv
// ibex_irq_ctrl_gen
// Interrupt front-end: captures software/timer/external/fast/NMI sources,
// masks them, picks the highest-priority one and hands a single request
// plus stable 6-bit cause to the controller, tracking handler nesting.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   irq_software_i, irq_timer_i, irq_external_i, irq_fast_i, irq_nm_i : sources
//   csr_mie_i, csr_mstatus_mie_i, debug_mode_i : masking
//   irq_ack_i, irq_done_i : controller handshake / handler exit
//   irq_req_o, irq_cause_o : request and cause
//   irq_pending_o : registered unmasked pending vector
//   in_handler_o, in_nmi_o : handler status
//   irq_count_o : accepted-interrupt counter (only with IBEX_IRQ_STATS_EN)
//
// state       | meaning
// IDLE        | no request, no handler active
// REQ         | request presented, cause frozen until ack or debug entry
// HANDLER     | maskable handler running; only NMI may request
// NMI_HANDLER | NMI handler running; everything blocked
module ibex_irq_ctrl_gen
  import ibex_irq_pkg::*;
#(
  parameter int unsigned          NUM_FAST  = 15,
  parameter logic [NUM_FAST-1:0] FAST_EDGE = {NUM_FAST{1'b0}}
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     irq_software_i,
  input  logic                     irq_timer_i,
  input  logic                     irq_external_i,
  input  logic [NUM_FAST-1:0]      irq_fast_i,
  input  logic                     irq_nm_i,
  input  logic [16+NUM_FAST-1:0]   csr_mie_i,
  input  logic                     csr_mstatus_mie_i,
  input  logic                     debug_mode_i,
  input  logic                     irq_ack_i,
  input  logic                     irq_done_i,
  output logic                     irq_req_o,
  output logic [5:0]               irq_cause_o,
  output logic [16+NUM_FAST-1:0]   irq_pending_o,
  output logic                     in_handler_o,
  output logic                     in_nmi_o,
  output logic [31:0]              irq_count_o
);

  localparam int unsigned W = IRQ_ID_FAST_BASE + NUM_FAST;

  irq_state_e          state_q, state_d;
  logic [4:0]          cause_id_q, cause_id_d;
  logic                ret_handler_q, ret_handler_d;
  logic                nmi_nested_q, nmi_nested_d;
  logic [NUM_FAST-1:0] fast_prev_q, fast_lat_q, fast_lat_d;
  logic                nm_prev_q, nmi_lat_q, nmi_lat_d;
  logic [W-1:0]        pend, pending_q;
  logic [31:0]         elig;
  logic                enc_valid;
  logic [4:0]          enc_id;
  logic                ack_take;

  // Debug entry beats a same-cycle ack: the request is withdrawn untaken.
  assign ack_take = (state_q == REQ) & irq_ack_i & ~debug_mode_i;

  always_comb begin
    pend = '0;
    pend[IRQ_ID_SW]    = irq_software_i;
    pend[IRQ_ID_TIMER] = irq_timer_i;
    pend[IRQ_ID_EXT]   = irq_external_i;
    for (int i = 0; i < NUM_FAST; i++) begin
      pend[IRQ_ID_FAST_BASE+i] = FAST_EDGE[i] ? fast_lat_q[i] : irq_fast_i[i];
    end
  end

  // Set wins over clear because the rise term is OR'ed in.
  always_comb begin
    for (int i = 0; i < NUM_FAST; i++) begin
      fast_lat_d[i] = FAST_EDGE[i] &
                      ((irq_fast_i[i] & ~fast_prev_q[i]) |
                       (fast_lat_q[i] &
                        ~(ack_take & (cause_id_q == 5'(IRQ_ID_FAST_BASE + i)))));
    end
    nmi_lat_d = (irq_nm_i & ~nm_prev_q) |
                (nmi_lat_q & ~(ack_take & (cause_id_q == 5'(IRQ_ID_NMI))));
  end

  always_comb begin
    elig = '0;
    elig[W-1:0] = pend & csr_mie_i & {W{csr_mstatus_mie_i & ~debug_mode_i}};
    elig[IRQ_ID_NMI] = nmi_lat_q & (state_q != NMI_HANDLER) & ~debug_mode_i;
  end

  ibex_irq_prio_enc u_prio_enc (
    .elig_i  (elig),
    .valid_o (enc_valid),
    .id_o    (enc_id)
  );

  always_comb begin
    state_d       = state_q;
    cause_id_d    = cause_id_q;
    ret_handler_d = ret_handler_q;
    nmi_nested_d  = nmi_nested_q;
    unique case (state_q)
      IDLE: begin
        if (enc_valid) begin
          cause_id_d    = enc_id;
          ret_handler_d = 1'b0;
          state_d       = REQ;
        end
      end
      REQ: begin
        if (debug_mode_i) begin
          ret_handler_d = 1'b0;
          state_d       = IDLE;
        end else if (irq_ack_i) begin
          ret_handler_d = 1'b0;
          if (cause_id_q == 5'(IRQ_ID_NMI)) begin
            nmi_nested_d = ret_handler_q;
            state_d      = NMI_HANDLER;
          end else begin
            state_d = HANDLER;
          end
        end
      end
      HANDLER: begin
        // Handler exit takes precedence; a waiting NMI is picked up from IDLE.
        if (irq_done_i) begin
          state_d = IDLE;
        end else if (elig[IRQ_ID_NMI]) begin
          cause_id_d    = 5'(IRQ_ID_NMI);
          ret_handler_d = 1'b1;
          state_d       = REQ;
        end
      end
      NMI_HANDLER: begin
        if (irq_done_i) begin
          state_d      = nmi_nested_q ? HANDLER : IDLE;
          nmi_nested_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cause_id_q    <= '0;
      ret_handler_q <= 1'b0;
      nmi_nested_q  <= 1'b0;
      fast_prev_q   <= '0;
      fast_lat_q    <= '0;
      nm_prev_q     <= 1'b0;
      nmi_lat_q     <= 1'b0;
      pending_q     <= '0;
    end else begin
      state_q       <= state_d;
      cause_id_q    <= cause_id_d;
      ret_handler_q <= ret_handler_d;
      nmi_nested_q  <= nmi_nested_d;
      fast_prev_q   <= irq_fast_i;
      fast_lat_q    <= fast_lat_d;
      nm_prev_q     <= irq_nm_i;
      nmi_lat_q     <= nmi_lat_d;
      pending_q     <= pend;
    end
  end

  assign irq_req_o     = (state_q == REQ);
  assign irq_cause_o   = (state_q == REQ) ? make_cause(cause_id_q) : 6'd0;
  assign irq_pending_o = pending_q;
  // A nested NMI request still runs inside the interrupted handler.
  assign in_handler_o  = (state_q == HANDLER) | (state_q == NMI_HANDLER) |
                         ((state_q == REQ) & ret_handler_q);
  assign in_nmi_o      = (state_q == NMI_HANDLER);

`ifdef IBEX_IRQ_STATS_EN
  logic [31:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (ack_take && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign irq_count_o = count_q;
`else
  assign irq_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_ibex_irq_ctrl_gen.sv
module tb_ibex_irq_ctrl_gen;

  localparam int NF = 15;
  localparam int W  = 16 + NF;
  localparam logic [NF-1:0] FE = 15'h0001;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          irq_software_i = 1'b0, irq_timer_i = 1'b0, irq_external_i = 1'b0;
  logic [NF-1:0] irq_fast_i = '0;
  logic          irq_nm_i = 1'b0;
  logic [W-1:0]  csr_mie_i = '0;
  logic          csr_mstatus_mie_i = 1'b0, debug_mode_i = 1'b0;
  logic          irq_ack_i = 1'b0, irq_done_i = 1'b0;
  logic          irq_req_o;
  logic [5:0]    irq_cause_o;
  logic [W-1:0]  irq_pending_o;
  logic          in_handler_o, in_nmi_o;
  logic [31:0]   irq_count_o;

  always #5 clk = ~clk;

  ibex_irq_ctrl_gen #(.NUM_FAST(NF), .FAST_EDGE(FE)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .irq_software_i(irq_software_i), .irq_timer_i(irq_timer_i),
    .irq_external_i(irq_external_i), .irq_fast_i(irq_fast_i), .irq_nm_i(irq_nm_i),
    .csr_mie_i(csr_mie_i), .csr_mstatus_mie_i(csr_mstatus_mie_i),
    .debug_mode_i(debug_mode_i), .irq_ack_i(irq_ack_i), .irq_done_i(irq_done_i),
    .irq_req_o(irq_req_o), .irq_cause_o(irq_cause_o), .irq_pending_o(irq_pending_o),
    .in_handler_o(in_handler_o), .in_nmi_o(in_nmi_o), .irq_count_o(irq_count_o)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: flags for "request shown", "maskable handler active",
  // "NMI handler active"; priority by scanning ids in the documented order.
  bit           m_req, m_mh, m_nh;
  int           m_cause;
  bit [NF-1:0]  m_lat, m_fprev;
  bit           m_nlat, m_nprev;
  bit [W-1:0]   m_preg;
  logic [31:0]  m_cnt;

  always @(posedge clk) begin : model
    bit [W-1:0] p;
    bit acc, nmi_ok;
    int win;
    int low_ids [3];
    low_ids = '{11, 3, 7};
    if (rst_i) begin
      m_req = 0; m_mh = 0; m_nh = 0; m_cause = 0;
      m_lat = '0; m_fprev = '0; m_nlat = 0; m_nprev = 0; m_preg = '0; m_cnt = '0;
    end else begin
      p = '0;
      p[3] = irq_software_i; p[7] = irq_timer_i; p[11] = irq_external_i;
      for (int i = 0; i < NF; i++) p[16+i] = FE[i] ? m_lat[i] : irq_fast_i[i];
      nmi_ok = m_nlat && !m_nh && !debug_mode_i;
      win = -1;
      if (nmi_ok) win = 31;
      else if (csr_mstatus_mie_i && !debug_mode_i) begin
        for (int k = NF - 1; k >= 0; k--)
          if (win < 0 && p[16+k] && csr_mie_i[16+k]) win = 16 + k;
        for (int k = 0; k < 3; k++)
          if (win < 0 && p[low_ids[k]] && csr_mie_i[low_ids[k]]) win = low_ids[k];
      end
      acc = m_req && irq_ack_i && !debug_mode_i;
      for (int i = 0; i < NF; i++)
        m_lat[i] = FE[i] && ((irq_fast_i[i] && !m_fprev[i]) || (m_lat[i] && !(acc && m_cause == 16 + i)));
      m_nlat = (irq_nm_i && !m_nprev) || (m_nlat && !(acc && m_cause == 31));
      m_fprev = irq_fast_i;
      m_nprev = irq_nm_i;
      m_preg  = p;
`ifdef IBEX_IRQ_STATS_EN
      if (acc && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
      if (m_req) begin
        if (debug_mode_i) begin m_req = 0; m_mh = 0; end
        else if (acc) begin
          m_req = 0;
          if (m_cause == 31) m_nh = 1; else m_mh = 1;
        end
      end else if (m_nh) begin
        if (irq_done_i) m_nh = 0;
      end else if (m_mh) begin
        if (irq_done_i) m_mh = 0;
        else if (nmi_ok) begin m_req = 1; m_cause = 31; end
      end else if (win >= 0) begin
        m_req = 1; m_cause = win;
      end
    end
  end

  always @(negedge clk) begin
    logic [5:0] exp_cause;
    if (chk_en) begin
      exp_cause = m_req ? {1'b1, 5'(m_cause)} : 6'd0;
      chk("req", 32'(irq_req_o), 32'(m_req));
      chk("cause", 32'(irq_cause_o), 32'(exp_cause));
      chk("pending", 32'(irq_pending_o), 32'(m_preg));
      chk("in_handler", 32'(in_handler_o), 32'(m_mh | m_nh));
      chk("in_nmi", 32'(in_nmi_o), 32'(m_nh));
      chk("count", irq_count_o, m_cnt);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic serve();
    irq_ack_i = 1; step(1); irq_ack_i = 0;
    irq_done_i = 1; step(1); irq_done_i = 0;
    step(1);
  endtask

  initial begin
    step(1);
    chk_en = 1'b1;
    step(1);
    rst_i = 0;
    step(1);
    chk("rst_req", 32'(irq_req_o), 32'd0);
    chk("rst_pend", 32'(irq_pending_o), 32'd0);

    // Timer only
    csr_mie_i[7] = 1; csr_mstatus_mie_i = 1; irq_timer_i = 1;
    step(1);
    chk("tmr_req", 32'(irq_req_o), 32'd1);
    chk("tmr_cause", 32'(irq_cause_o), 32'h27);
    irq_ack_i = 1; step(1); irq_ack_i = 0;
    chk("tmr_inh", 32'(in_handler_o), 32'd1);
    irq_ack_i = 1; step(1); irq_ack_i = 0;
    chk("ack_ignored", 32'(in_handler_o), 32'd1);
    irq_done_i = 1; step(1); irq_done_i = 0;
    chk("tmr_idle", 32'(irq_req_o | in_handler_o), 32'd0);
    step(1);
    chk("tmr_rereq", 32'(irq_cause_o), 32'h27);
    irq_timer_i = 0;
    serve();

    // Priority: fast[2] > external > software > timer
    csr_mie_i = '1;
    irq_software_i = 1; irq_external_i = 1; irq_fast_i[2] = 1; irq_timer_i = 1;
    step(1);
    chk("prio_fast", 32'(irq_cause_o), 32'h32);
    irq_fast_i[2] = 0; serve();
    chk("prio_ext", 32'(irq_cause_o), 32'h2B);
    irq_external_i = 0; serve();
    chk("prio_sw", 32'(irq_cause_o), 32'h23);
    irq_software_i = 0; serve();
    chk("prio_tmr", 32'(irq_cause_o), 32'h27);
    irq_timer_i = 0; serve();

    // Edge capture on fast[0]
    csr_mstatus_mie_i = 0;
    irq_fast_i[0] = 1; step(1); irq_fast_i[0] = 0;
    step(3);
    chk("edge_noreq", 32'(irq_req_o), 32'd0);
    chk("edge_pend", 32'(irq_pending_o[16]), 32'd1);
    csr_mstatus_mie_i = 1;
    step(1);
    chk("edge_cause", 32'(irq_cause_o), 32'h30);
    serve();
    step(1);
    chk("edge_clr_req", 32'(irq_req_o), 32'd0);
    chk("edge_clr_pend", 32'(irq_pending_o[16]), 32'd0);

    // NMI nesting inside a timer handler
    irq_timer_i = 1;
    step(1);
    irq_ack_i = 1; irq_timer_i = 0; step(1); irq_ack_i = 0;
    irq_nm_i = 1; step(1); irq_nm_i = 0;
    step(1);
    chk("nmi_cause", 32'(irq_cause_o), 32'h3F);
    chk("nmi_req_inh", 32'(in_handler_o), 32'd1);
    irq_ack_i = 1; step(1); irq_ack_i = 0;
    chk("nmi_in", 32'(in_nmi_o), 32'd1);
    irq_nm_i = 1; step(1); irq_nm_i = 0;
    step(2);
    chk("nmi_blocked", 32'(irq_req_o), 32'd0);
    irq_done_i = 1; step(1); irq_done_i = 0;
    chk("nmi_ret_nmi", 32'(in_nmi_o), 32'd0);
    chk("nmi_ret_inh", 32'(in_handler_o), 32'd1);
    irq_done_i = 1; step(1); irq_done_i = 0;
    chk("nmi_idle", 32'(in_handler_o | irq_req_o), 32'd0);
    step(1);
    chk("nmi_second", 32'(irq_cause_o), 32'h3F);
    serve();

    // Debug withdraws a pending request
    irq_timer_i = 1;
    step(1);
    debug_mode_i = 1; step(1);
    chk("dbg_drop", 32'(irq_req_o), 32'd0);
    step(2);
    chk("dbg_hold", 32'(irq_req_o), 32'd0);
    debug_mode_i = 0; step(1);
    chk("dbg_back", 32'(irq_cause_o), 32'h27);
    irq_timer_i = 0; serve();

    // Reset while a request is shown
    csr_mstatus_mie_i = 0;
    irq_fast_i[0] = 1; step(1); irq_fast_i[0] = 0;
    step(1);
    csr_mstatus_mie_i = 1; step(1);
    chk("rr_req", 32'(irq_req_o), 32'd1);
    rst_i = 1; step(1); rst_i = 0;
    chk("rr_req0", 32'(irq_req_o), 32'd0);
    chk("rr_cause0", 32'(irq_cause_o), 32'd0);
    chk("rr_pend0", 32'(irq_pending_o), 32'd0);
    chk("rr_hdl0", 32'(in_handler_o | in_nmi_o), 32'd0);
    chk("rr_cnt0", irq_count_o, 32'd0);
    step(2);
    chk("rr_latch_req", 32'(irq_req_o), 32'd0);
    chk("rr_latch_pend", 32'(irq_pending_o), 32'd0);

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
